// File: rtl/bt_tx.sv
// bt_tx: 8N1 UART transmitter with a small byte FIFO for back-to-back frames
module bt_tx #(
  parameter int BPS   = 10417,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic [AW:0]   level,
  output logic          tx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        st;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [14:0]   cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          bit_end, pop, push;
  logic [AW:0]   lvl_nxt;
  assign bit_end = cnt == 15'(BPS - 1);
  // pop is decided first so a full FIFO can still take a push on a pop edge
  assign pop     = !empty && (st == IDLE || (st == STOP && bit_end));
  assign push    = wr_en && (!full || pop);
  assign lvl_nxt = level + (AW+1)'(push) - (AW+1)'(pop);
  assign busy    = st != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      rd    <= '0;
      wr    <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) begin
        rd <= rd + 1'b1;
        sh <= mem[rd];
      end
      level <= lvl_nxt;
      full  <= lvl_nxt == (AW+1)'(DEPTH);
      empty <= lvl_nxt == '0;
      cnt   <= (st == IDLE || bit_end) ? 15'd0 : cnt + 15'd1;
      case (st)
        IDLE:  if (pop) begin
                 st <= START;
                 tx <= 1'b0;
               end
        START: if (bit_end) begin
                 st  <= DATA;
                 idx <= 3'd0;
                 tx  <= sh[0];
               end
        DATA:  if (bit_end) begin
                 idx <= idx + 3'd1;
                 tx  <= (idx == 3'd7) ? 1'b1 : sh[idx + 3'd1];
                 if (idx == 3'd7) st <= STOP;
               end
        STOP:  if (bit_end) begin
                 st <= pop ? START : IDLE;
                 tx <= !pop;
               end
      endcase
    end
  end
endmodule

// File: tb/tb_bt_tx.sv
// tb_bt_tx: scoreboard bench decoding tx at mid-bit against queued bytes
module tb_bt_tx;
  logic       clk = 0, rst = 1, wr_en = 0;
  logic [7:0] wr_data = 0;
  logic       full, empty, busy, tx;
  logic [2:0] level;
  int         cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] q[$];
  int         starts[$];
  bit         dbusy = 0;

  bt_tx #(.BPS(16), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .busy(busy), .level(level), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit keep);
    @(posedge clk); #1;
    wr_en = 1;
    wr_data = d;
    if (keep) q.push_back(d);
  endtask

  task automatic end_push;
    @(posedge clk); #1;
    wr_en = 0;
    wr_data = 8'hEE;
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((busy || !empty || q.size() != 0 || dbusy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 3000, 1);
  endtask

  initial begin : dec
    int dcnt;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst) dbusy = 0;
      else if (!dbusy) begin
        if (tx === 1'b0) begin
          dbusy = 1;
          dcnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        dcnt++;
        if (dcnt == 8) check("start_bit", tx, 0);
        else if (dcnt >= 24 && dcnt <= 136 && dcnt % 16 == 8) b[(dcnt-24)/16] = tx;
        else if (dcnt == 152) begin
          check("stop_bit", tx, 1);
          check("sb_nonempty", q.size() != 0, 1);
          if (q.size() != 0) check("byte", b, q.pop_front());
          dbusy = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s, n;
    bit low;
    logic t15, t16;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    low = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) low = 1;
    end
    check("idle_quiet", low, 0);

    push(8'hA5, 1);
    end_push;
    @(negedge clk);
    check("s2_empty", empty, 0);
    check("s2_tx_pre", tx, 1);
    @(negedge clk);
    check("s2_tx_start", tx, 0);
    check("s2_busy", busy, 1);
    n = 0;
    t15 = 1'bx;
    t16 = 1'bx;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 15) t15 = tx;
      if (n == 16) t16 = tx;
    end
    check("s2_busy_len", n, 160);
    check("s2_start_end", t15, 0);
    check("s2_bit0", t16, 1);
    wait_idle;

    starts.delete();
    push(8'h01, 1);
    push(8'h80, 1);
    push(8'hFF, 1);
    end_push;
    k = cyc - 2;
    wait_idle;
    check("s3_nstarts", starts.size(), 3);
    if (starts.size() >= 3) begin
      check("s3_first", starts[0] - k, 1);
      check("s3_gap1", starts[1] - starts[0], 160);
      check("s3_gap2", starts[2] - starts[1], 160);
    end

    push(8'h20, 1);
    end_push;
    @(negedge clk);
    @(negedge clk);
    check("s4_busy", busy, 1);
    push(8'h10, 1);
    push(8'h11, 1);
    push(8'h12, 1);
    push(8'h13, 1);
    push(8'h14, 0);
    @(negedge clk);
    check("s4_full", full, 1);
    check("s4_level", level, 4);
    end_push;
    @(negedge clk);
    check("s4_drop_level", level, 4);
    check("s4_drop_full", full, 1);
    wait_idle;
    check("s4_level0", level, 0);
    check("s4_empty", empty, 1);

    push(8'h30, 1);
    end_push;
    s = cyc;
    push(8'h31, 1);
    push(8'h32, 1);
    push(8'h33, 1);
    push(8'h34, 1);
    end_push;
    @(negedge clk);
    check("s5_pre_full", full, 1);
    while (cyc < s + 160) begin
      @(posedge clk); #1;
    end
    wr_en = 1;
    wr_data = 8'h3C;
    q.push_back(8'h3C);
    @(posedge clk); #1;
    wr_en = 0;
    wr_data = 8'hEE;
    @(negedge clk);
    check("s5_level", level, 4);
    check("s5_full", full, 1);
    wait_idle;

    push(8'h40, 0);
    push(8'h41, 0);
    push(8'h42, 0);
    end_push;
    s = cyc - 2;
    while (cyc < s + 73) begin
      @(posedge clk); #1;
    end
    check("s6_in_frame", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("s6_tx", tx, 1);
    check("s6_empty", empty, 1);
    check("s6_busy", busy, 0);
    check("s6_level", level, 0);
    push(8'h55, 1);
    end_push;
    wait_idle;
    check("s6_level0", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bt_tx.md
Name: bt_tx

Overview:
- UART transmitter for the Bluetooth serial link: 8N1, LSB first, idle-high line, 9600 baud at 100 MHz. It is the transmit direction of the link whose receiver feeds `choice`/`dir` into the game logic.
- Game logic pushes status bytes into a small internal FIFO. The block serialises them onto `tx` back-to-back, which lets logic report events faster than the line can drain them.

Parameters:
- BPS, 10417, clock cycles per bit (100 MHz / 9600).
- DEPTH, 4, FIFO entries; must be a power of 2, 2..16.
- AW, 2, FIFO address width, log2(DEPTH).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  push request; wr_data is accepted on the edge where wr_en=1 and full=0.
- wr_data  input  8  byte to transmit.
- full  output  1  FIFO holds DEPTH entries; pushes are dropped.
- empty  output  1  FIFO holds 0 entries.
- busy  output  1  FSM not in IDLE (a frame is on the line).
- level  output  AW+1  current FIFO occupancy, 0..DEPTH.
- tx  output  1  serial line, driven from a register.

Behaviour:
- Reset (rst=1 at an edge):
  - tx=1, busy=0, empty=1, full=0, level=0.
  - FSM=IDLE; pointers, bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame immediately; tx=1 on the next cycle and queued bytes are discarded.
- FIFO:
  - Circular buffer with rd/wr pointers of AW bits that wrap modulo DEPTH, plus a level counter of AW+1 bits.
  - A push happens when wr_en and !full.
  - A pop happens only in the FSM load events described below.
  - Simultaneous push and pop: both pointers advance and level is unchanged. This is legal even when full, because the pop is decided first, so level==DEPTH with a pop allows the push.
  - Push while full with no pop: byte dropped, level stays DEPTH, no pointer change.
  - full, empty and level are registered outputs derived from the level counter, valid in the cycle after the edge.
- FSM states: IDLE, START, DATA, STOP.
  - Baud counter cnt runs 0..BPS-1 in every non-IDLE state; bit_end = (cnt==BPS-1).
  - IDLE: tx=1. If !empty, pop the head into shift register sh[7:0], clear cnt, go to START.
  - START: tx=0. On bit_end go to DATA, with bit index idx=0.
  - DATA: tx=sh[idx]. On bit_end:
    - if idx==7, go to STOP;
    - else idx+1.
  - STOP: tx=1. On bit_end:
    - if !empty, pop the next byte and go directly to START (no idle gap);
    - else go to IDLE.
- Latency:
  - A push at edge k into an empty FIFO with FSM in IDLE makes empty=0 after edge k.
  - The FSM pops at edge k+1; tx falls to 0 after edge k+1.
  - busy=1 from edge k+1 until the edge that returns the FSM to IDLE.
- Frame timing:
  - Each bit lasts exactly BPS cycles.
  - A frame is 10*BPS cycles.
  - Consecutive queued bytes are exactly 10*BPS cycles apart, start bit to start bit.
- Width and overflow:
  - cnt is 15 bits (BPS ≤ 32767).
  - idx is 3 bits.
  - level never exceeds DEPTH.
- wr_data is captured only at the push edge; changes afterwards do not affect a queued byte.

Test Plan:
- Simulation uses BPS=16, DEPTH=4. "Decoded" means sampling tx at mid-bit, offset 8 within each bit.
- Scenario 1, reset: hold rst 3 cycles, then release -> tx=1, busy=0, empty=1, full=0, level=0. No activity for 200 cycles.
- Scenario 2, single byte: push 8'hA5 at edge k ->
  - tx=0 from k+1 for 16 cycles;
  - then bits 1,0,1,0,0,1,0,1, each 16 cycles;
  - then stop=1;
  - busy falls at k+1+160, and the decoded byte is 8'hA5.
- Scenario 3, back-to-back: push 8'h01, 8'h80, 8'hFF on consecutive cycles ->
  - start bits at k+1, k+161, k+321;
  - tx stays high through each stop bit with no extra idle cycle;
  - decoded bytes are 01, 80, FF in that order.
- Scenario 4, overflow: while the first frame is sending, push 5 more bytes (10..14) ->
  - full=1 after the 4th accepted push;
  - byte 14 is dropped;
  - the line carries the first byte then 10, 11, 12, 13, and level goes to 0.
- Scenario 5, simultaneous push and pop: FIFO full, push 8'h3C on the exact edge the STOP state pops ->
  - push accepted, level stays 4;
  - 8'h3C is transmitted last.
- Scenario 6, reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued ->
  - tx=1 next cycle, empty=1, busy=0;
  - a new push of 8'h55 transmits a clean full frame.
